// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : Multi-port integer register file with two prioritised write
//               ports (port 1 wins), NRD combinational read ports with
//               write-through bypass, and a per-register pending-write
//               scoreboard for RAW hazard stalls. Register 0 reads as zero.
//               Optional macro RF_STALL_CNT_EN adds a saturating 32-bit
//               counter of cycles in which any read port is busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
`ifdef RF_STALL_CNT_EN
  ,
  input  logic                stall_cnt_clr,
  output logic [31:0]         stall_cnt
`endif
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;

  // Register storage: port 1 overrides port 0 on an address collision;
  // entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wr1_en && (wr1_addr == AW'(i))) begin
          r_regs[i] <= wr1_data;
        end else if (wr0_en && (wr0_addr == AW'(i))) begin
          r_regs[i] <= wr0_data;
        end
      end
    end
  end

  // Scoreboard next state: flush beats alloc, alloc beats a release.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NREGS; i++) begin
      if (flush) begin
        w_busy_nxt[i] = 1'b0;
      end else if (alloc_en && (alloc_addr == AW'(i))) begin
        w_busy_nxt[i] = 1'b1;
      end else if ((wr1_en && (wr1_addr == AW'(i))) ||
                   (wr0_en && (wr0_addr == AW'(i)))) begin
        w_busy_nxt[i] = 1'b0;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic            w_hit0;
    logic            w_hit1;
    logic [XLEN-1:0] w_data;
    logic            w_busy;

    assign w_addr = rd_addr[k*AW +: AW];
    assign w_hit1 = wr1_en && (wr1_addr == w_addr);
    assign w_hit0 = wr0_en && (wr0_addr == w_addr);

    // Read mux with bypass; an in-flight writeback resolves the hazard.
    always_comb begin
      w_data = r_regs[w_addr];
      w_busy = r_busy[w_addr] && !w_hit0 && !w_hit1;
      if (w_addr == '0) begin
        w_data = '0;
        w_busy = 1'b0;
      end else if (w_hit1) begin
        w_data = wr1_data;
      end else if (w_hit0) begin
        w_data = wr0_data;
      end
    end

    assign rd_data[k*XLEN +: XLEN] = w_data;
    assign rd_busy[k]              = w_busy;
  end

`ifdef RF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating stall-cycle counter; clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      r_stall_cnt <= '0;
    end else if ((|rd_busy) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_mp_sb
// Description : Scoreboard bench for regfile_mp_sb. Stimulus queues expected
//               values just after each rising edge; a monitor on the falling
//               edge pops and compares them against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp_sb;
  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  localparam int K_D0  = 0;
  localparam int K_D1  = 1;
  localparam int K_RB  = 2;
  localparam int K_BV  = 3;
  localparam int K_SC  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr0_en, wr1_en, alloc_en, flush;
  logic [AW-1:0]       wr0_addr, wr1_addr, alloc_addr;
  logic [XLEN-1:0]     wr0_data, wr1_data;
  logic [NREGS-1:0]    busy_vec;
`ifdef RF_STALL_CNT_EN
  logic                stall_cnt_clr;
  logic [31:0]         stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  string       q_name [$];
  int          q_kind [$];
  logic [63:0] q_val  [$];

  regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr0_en     (wr0_en),
    .wr0_addr   (wr0_addr),
    .wr0_data   (wr0_data),
    .wr1_en     (wr1_en),
    .wr1_addr   (wr1_addr),
    .wr1_data   (wr1_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy_vec   (busy_vec)
`ifdef RF_STALL_CNT_EN
    ,
    .stall_cnt_clr (stall_cnt_clr),
    .stall_cnt     (stall_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    string       nm;
    int          kd;
    logic [63:0] ev;
    logic [63:0] av;
    while (q_kind.size() > 0) begin
      nm = q_name.pop_front();
      kd = q_kind.pop_front();
      ev = q_val.pop_front();
      case (kd)
        K_D0:    av = rd_data[63:0];
        K_D1:    av = rd_data[127:64];
        K_RB:    av = {62'd0, rd_busy};
        K_BV:    av = {32'd0, busy_vec};
`ifdef RF_STALL_CNT_EN
        K_SC:    av = {32'd0, stall_cnt};
`endif
        default: av = 64'hDEAD_DEAD_DEAD_DEAD;
      endcase
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL %s: got %h want %h", nm, av, ev);
      end
    end
  end

  task automatic push_exp(input string nm, input int kd, input logic [63:0] v);
    q_name.push_back(nm);
    q_kind.push_back(kd);
    q_val.push_back(v);
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
`ifdef RF_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted with arbitrary activity on the inputs.
    rst = 1'b1;
    rd_addr = {5'd3, 5'd6};
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h1111;
    wr1_en = 1'b1; wr1_addr = 5'd6; wr1_data = 64'h2222;
    alloc_en = 1'b1; alloc_addr = 5'd6; flush = 1'b0;
`ifdef RF_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    step(); step();
    rst = 1'b0; idle();
    rd_addr = {5'd5, 5'd0};
    push_exp("reset_d0", K_D0, 64'd0);
    push_exp("reset_d1", K_D1, 64'd0);
    push_exp("reset_busy", K_RB, 64'd0);
    push_exp("reset_bvec", K_BV, 64'd0);
    step();
    rd_addr = {5'd6, 5'd3};
    push_exp("reset_reg3", K_D0, 64'd0);
    push_exp("reset_reg6", K_D1, 64'd0);

    // Same-address dual write: port 1 wins in bypass and storage.
    step(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 64'h22;
    rd_addr = {5'd0, 5'd7};
    push_exp("prio_bypass", K_D0, 64'h22);
    step(); idle();
    rd_addr = {5'd7, 5'd7};
    push_exp("prio_store0", K_D0, 64'h22);
    push_exp("prio_store1", K_D1, 64'h22);

    // Different-address dual write.
    step(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'hAA;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 64'hBB;
    rd_addr = {5'd4, 5'd3};
    push_exp("dual_byp0", K_D0, 64'hAA);
    push_exp("dual_byp1", K_D1, 64'hBB);
    step(); idle();
    push_exp("dual_reg3", K_D0, 64'hAA);
    push_exp("dual_reg4", K_D1, 64'hBB);

    // Register 0 immunity.
    step(); idle();
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 64'hFFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    rd_addr = {5'd4, 5'd0};
    push_exp("x0_byp", K_D0, 64'd0);
    push_exp("x0_busy", K_RB, 64'd0);
    step(); idle();
    push_exp("x0_data", K_D0, 64'd0);
    push_exp("x0_bvec", K_BV, 64'd0);

    // RAW hazard: alloc at t, visible from t+1, released by wr0 at t+3.
    step(); idle();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    rd_addr = {5'd4, 5'd9};
    push_exp("alloc_same_cycle", K_RB, 64'd0);
    step(); idle();
    push_exp("haz_busy_t1", K_RB, 64'd1);
    push_exp("haz_bvec_t1", K_BV, 64'h200);
    step(); idle();
    push_exp("haz_busy_t2", K_RB, 64'd1);
    step(); idle();
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h55;
    push_exp("haz_busy_t3", K_RB, 64'd0);
    push_exp("haz_data_t3", K_D0, 64'h55);
    push_exp("haz_bvec_t3", K_BV, 64'h200);
    step(); idle();
    push_exp("haz_bvec_t4", K_BV, 64'd0);
    push_exp("haz_data_t4", K_D0, 64'h55);

    // Alloc and release of the same register in one cycle: alloc wins.
    step(); idle();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 64'h66;
    push_exp("ar_byp", K_D0, 64'h66);
    step(); idle();
    push_exp("ar_bvec", K_BV, 64'h200);
    push_exp("ar_busy", K_RB, 64'd1);
    push_exp("ar_data", K_D0, 64'h66);

    // Flush beats a same-cycle alloc.
    step(); idle();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd12;
    step(); idle();
    push_exp("flush_bvec", K_BV, 64'd0);
    push_exp("flush_busy", K_RB, 64'd0);

`ifdef RF_STALL_CNT_EN
    // Stall counter: clear, then 10 busy cycles, then clear again.
    step(); idle();
    rd_addr = '0;
    alloc_en = 1'b1; alloc_addr = 5'd2; stall_cnt_clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); idle();
      rd_addr = {5'd0, 5'd2};
    end
    step(); idle();
    rd_addr = '0;
    push_exp("stall_cnt10", K_SC, 64'd10);
    step(); idle();
    rd_addr = '0;
    stall_cnt_clr = 1'b1;
    step(); idle();
    push_exp("stall_clr", K_SC, 64'd0);
`endif

    // Async reset mid-flight.
    step(); idle();
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 64'h1234;
    step(); idle();
    alloc_en = 1'b1; alloc_addr = 5'd2;
    step(); idle();
    alloc_en = 1'b1; alloc_addr = 5'd5;
    step(); idle();
    rd_addr = {5'd5, 5'd2};
    push_exp("pre_rst_bvec", K_BV, 64'h24);
    push_exp("pre_rst_data", K_D0, 64'h1234);
    push_exp("pre_rst_busy", K_RB, 64'd3);
    step(); idle();
    rst = 1'b1;
    alloc_en = 1'b1; alloc_addr = 5'd7;
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'h77;
    push_exp("arst_bvec", K_BV, 64'd0);
    push_exp("arst_data", K_D0, 64'd0);
    push_exp("arst_busy", K_RB, 64'd0);
    step(); idle();
    rst = 1'b0;
    rd_addr = {5'd7, 5'd2};
    push_exp("post_rst_reg2", K_D0, 64'd0);
    push_exp("post_rst_reg7", K_D1, 64'd0);
    push_exp("post_rst_bvec", K_BV, 64'd0);

    @(negedge clk);
    @(negedge clk);
    if (q_kind.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q_kind.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
